// File: rtl/acq_sched.sv
// acq_sched: triggered ADC frame capture into ping-pong buffers with PGA auto-ranging.
// The trigger is synchronised, divided adc_clk is generated and samples are written with peak tracking.
module acq_sched #(
  parameter int DATA_WIDTH = 12,
  parameter int BUF_SIZE = 1024,
  parameter int HI_TH = 3800,
  parameter int LO_TH = 900,
  localparam int AW = $clog2(BUF_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  signal_in,
  input  logic [DATA_WIDTH-1:0] adc_data,
  input  logic [15:0]           div_cfg,
  input  logic                  mcu_rd_busy,
  input  logic                  ovr_clr,
  input  logic                  gain_auto_en,
  input  logic [1:0]            gain_manual,
  output logic                  adc_clk,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_buf,
  output logic                  buf_ready,
  output logic [1:0]            gain_ctrl,
  output logic                  gain_stable,
  output logic                  overrun,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, SWAP} state_t;
  localparam logic [DATA_WIDTH-1:0] HI = DATA_WIDTH'(HI_TH);
  localparam logic [DATA_WIDTH-1:0] LO = DATA_WIDTH'(LO_TH);
  state_t r_state, w_next;
  logic [1:0] r_sync;
  logic r_prev;
  logic [2:0] r_vld;
  logic [15:0] r_n, r_cnt;
  logic [AW-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_max, r_min;
  logic r_buf, r_ovr;
  logic [1:0] r_gain, r_unch, w_gain;
  logic w_trig, w_cnt_end, w_wr, w_last, w_swap, w_start;
  logic [DATA_WIDTH-1:0] w_pp;
  // r_vld masks the edge detector until the synchroniser holds real input, so a level held across reset is not an edge
  assign w_trig = r_vld[2] & r_sync[1] & ~r_prev;
  assign w_cnt_end = r_cnt == r_n - 16'd1;
  assign w_wr = (r_state == CAPTURE) & enable & w_cnt_end;
  assign w_last = w_wr & (r_addr == AW'(BUF_SIZE - 1));
  assign w_swap = (r_state == SWAP) & enable;
  assign w_start = (r_state == ARM) & enable & w_trig;
  assign w_pp = r_max - r_min;
  assign w_gain = (w_pp > HI && r_gain != 2'd0) ? r_gain - 2'd1 :
                  (w_pp < LO && r_gain != 2'd3) ? r_gain + 2'd1 : r_gain;
  assign adc_clk = (r_state == CAPTURE) && (r_cnt < (r_n >> 1));
  assign wr_en = w_wr;
  assign wr_addr = r_addr;
  assign wr_data = w_wr ? adc_data : '0;
  assign wr_buf = r_buf;
  assign buf_ready = w_swap & ~mcu_rd_busy;
  assign gain_ctrl = r_gain;
  assign gain_stable = r_unch == 2'd2;
  assign overrun = r_ovr;
  assign busy = r_state == CAPTURE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = ARM;
      ARM:     w_next = w_trig ? CAPTURE : ARM;
      CAPTURE: w_next = w_last ? SWAP : CAPTURE;
      default: w_next = ARM;
    endcase
    if (!enable) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sync <= '0;
      r_prev <= 1'b0;
      r_vld <= '0;
      r_n <= 16'd2;
      r_cnt <= '0;
      r_addr <= '0;
      r_max <= '0;
      r_min <= '0;
      r_buf <= 1'b0;
      r_ovr <= 1'b0;
      r_gain <= '0;
      r_unch <= '0;
    end else begin
      r_state <= w_next;
      r_sync <= {r_sync[0], signal_in};
      r_prev <= r_sync[1];
      r_vld <= {r_vld[1:0], 1'b1};
      if (w_start) begin
        r_n <= (div_cfg < 16'd2) ? 16'd2 : div_cfg;
        r_cnt <= '0;
        r_addr <= '0;
        r_max <= '0;
        r_min <= '1;
      end else if (r_state == CAPTURE) begin
        r_cnt <= w_cnt_end ? 16'd0 : r_cnt + 16'd1;
      end
      if (w_wr) begin
        r_addr <= w_last ? '0 : r_addr + AW'(1);
        if (adc_data > r_max) r_max <= adc_data;
        if (adc_data < r_min) r_min <= adc_data;
      end
      if (!enable) r_addr <= '0;
      if (w_swap && !mcu_rd_busy) r_buf <= ~r_buf;
      // a new overrun wins over a simultaneous clear
      r_ovr <= (w_swap & mcu_rd_busy) | (r_ovr & ~ovr_clr);
      if (!gain_auto_en) begin
        r_gain <= gain_manual;
        r_unch <= 2'd2;
      end else if (w_swap) begin
        r_gain <= w_gain;
        r_unch <= (w_gain != r_gain) ? 2'd0 : (r_unch == 2'd2) ? 2'd2 : r_unch + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_acq_sched.sv
// tb_acq_sched: directed scenario tasks for acq_sched with a passive negedge monitor of the write stream.
module tb_acq_sched;
  localparam int DW = 12;
  localparam int AW = 10;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, signal_in = 1'b0;
  logic mcu_rd_busy = 1'b0, ovr_clr = 1'b0, gain_auto_en = 1'b0;
  logic [DW-1:0] adc_data = 12'h5A5;
  logic [15:0] div_cfg = 16'd4;
  logic [1:0] gain_manual = 2'd0;
  logic adc_clk, wr_en, wr_buf, buf_ready, gain_stable, overrun, busy;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [1:0] gain_ctrl;
  int checks = 0, errors = 0;
  bit ramp = 1'b0;
  logic [DW-1:0] const_val = 12'd2000;
  int mon_n, exp_addr, addr_err, clk_err, wr_err, data_err, mon_rdy, ph, exp_n = 2;
  bit cap_ok, end_ok, swap_rdy;
  logic exp_buf = 1'b0;

  acq_sched dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .signal_in(signal_in), .adc_data(adc_data),
    .div_cfg(div_cfg), .mcu_rd_busy(mcu_rd_busy), .ovr_clr(ovr_clr), .gain_auto_en(gain_auto_en),
    .gain_manual(gain_manual), .adc_clk(adc_clk), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_buf(wr_buf), .buf_ready(buf_ready), .gain_ctrl(gain_ctrl), .gain_stable(gain_stable),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Expected adc_clk/wr_en pattern: phase ph runs 0..N-1 from the first busy cycle, write at N-1.
  always @(negedge clk) begin
    if (busy) begin
      if (adc_clk !== (ph < exp_n / 2)) clk_err++;
      if (wr_en !== (enable && ph == exp_n - 1)) wr_err++;
      ph = (ph == exp_n - 1) ? 0 : ph + 1;
    end else begin
      if (adc_clk !== 1'b0 || wr_en !== 1'b0) wr_err++;
      ph = 0;
    end
    if (wr_en) begin
      if (wr_addr !== AW'(exp_addr)) addr_err++;
      if (wr_data !== adc_data) data_err++;
      exp_addr++;
      mon_n++;
    end
    if (buf_ready) mon_rdy++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
    adc_data = ramp ? DW'(mon_n * 4) : const_val;
  endtask

  task automatic clr_mon(input int n);
    mon_n = 0; exp_addr = 0; addr_err = 0; clk_err = 0; wr_err = 0; data_err = 0; mon_rdy = 0; ph = 0;
    exp_n = n;
  endtask

  task automatic start_cap(output bit ok);
    ok = 1'b0;
    signal_in = 1'b1;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick;
      ok = busy;
    end
    signal_in = 1'b0;
  endtask

  task automatic end_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8000 && !ok; i++) begin
      tick;
      ok = !busy;
    end
  endtask

  task automatic run_frame(input int n, input logic [15:0] cfg, input logic [15:0] mid);
    div_cfg = cfg;
    clr_mon(n);
    start_cap(cap_ok);
    div_cfg = mid;
    end_frame(end_ok);
    swap_rdy = buf_ready;
    tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    gain_auto_en = 1'b1;
    #12;
    checks++;
    if ({adc_clk, wr_en, buf_ready, busy, wr_buf, overrun, gain_stable} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000000", {adc_clk, wr_en, buf_ready, busy, wr_buf, overrun, gain_stable});
    end
    checks++;
    if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
    checks++;
    if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data: got %0h expected 0", wr_data); end
    checks++;
    if (gain_ctrl !== 2'd0) begin errors++; $display("FAIL reset_gain: got %0d expected 0", gain_ctrl); end
    @(negedge clk) rst_n = 1'b1;
    tick;
    tick;
  endtask

  task automatic test_gain_manual;
    gain_auto_en = 1'b0;
    gain_manual = 2'd2;
    checks++;
    if (gain_ctrl !== 2'd0) begin errors++; $display("FAIL manual_latency: got %0d expected 0", gain_ctrl); end
    tick;
    checks++;
    if (gain_ctrl !== 2'd2) begin errors++; $display("FAIL manual_gain: got %0d expected 2", gain_ctrl); end
    checks++;
    if (gain_stable !== 1'b1) begin errors++; $display("FAIL manual_stable: got %b expected 1", gain_stable); end
    gain_manual = 2'd0;
    tick;
  endtask

  task automatic test_frame_div4;
    enable = 1'b1;
    ramp = 1'b1;
    tick;
    tick;
    run_frame(4, 16'd4, 16'd4);
    exp_buf = ~exp_buf;
    checks++;
    if (!(cap_ok && end_ok)) begin errors++; $display("FAIL div4_timeout: got start=%b end=%b expected 1 1", cap_ok, end_ok); end
    checks++;
    if (mon_n != 1024) begin errors++; $display("FAIL div4_writes: got %0d expected 1024", mon_n); end
    checks++;
    if (addr_err + clk_err + wr_err + data_err != 0) begin
      errors++;
      $display("FAIL div4_stream: got addr=%0d clk=%0d wr=%0d data=%0d errors expected 0", addr_err, clk_err, wr_err, data_err);
    end
    checks++;
    if (!(swap_rdy && mon_rdy == 1)) begin errors++; $display("FAIL div4_ready: got swap=%b pulses=%0d expected 1 1", swap_rdy, mon_rdy); end
    checks++;
    if (wr_buf !== exp_buf) begin errors++; $display("FAIL div4_wr_buf: got %b expected %b", wr_buf, exp_buf); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL div4_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_div_small;
    for (int k = 0; k < 3; k++) begin
      logic [15:0] cfg;
      cfg = (k == 0) ? 16'd0 : (k == 1) ? 16'd1 : 16'd5;
      run_frame(k == 2 ? 5 : 2, cfg, k == 2 ? 16'd3 : cfg);
      exp_buf = ~exp_buf;
      checks++;
      if (!(cap_ok && end_ok && mon_n == 1024)) begin
        errors++;
        $display("FAIL div%0d_writes: got %0d (start=%b end=%b) expected 1024", cfg, mon_n, cap_ok, end_ok);
      end
      checks++;
      if (addr_err + clk_err + wr_err + data_err != 0) begin
        errors++;
        $display("FAIL div%0d_stream: got addr=%0d clk=%0d wr=%0d data=%0d errors expected 0", cfg, addr_err, clk_err, wr_err, data_err);
      end
      checks++;
      if (wr_buf !== exp_buf || mon_rdy != 1) begin
        errors++;
        $display("FAIL div%0d_swap: got wr_buf=%b pulses=%0d expected %b 1", cfg, wr_buf, mon_rdy, exp_buf);
      end
    end
  endtask

  task automatic test_overrun;
    ramp = 1'b0;
    mcu_rd_busy = 1'b1;
    run_frame(2, 16'd2, 16'd2);
    checks++;
    if (swap_rdy || mon_rdy != 0) begin errors++; $display("FAIL ovr_no_ready: got swap=%b pulses=%0d expected 0 0", swap_rdy, mon_rdy); end
    checks++;
    if (wr_buf !== exp_buf) begin errors++; $display("FAIL ovr_wr_buf: got %b expected %b", wr_buf, exp_buf); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    tick;
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    ovr_clr = 1'b1;
    tick;
    ovr_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
    ovr_clr = 1'b1;
    run_frame(2, 16'd2, 16'd2);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b expected 1", overrun); end
    tick;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr_after: got %b expected 0", overrun); end
    ovr_clr = 1'b0;
    mcu_rd_busy = 1'b0;
  endtask

  task automatic test_abort;
    bit ok;
    ramp = 1'b1;
    div_cfg = 16'd2;
    clr_mon(2);
    start_cap(ok);
    for (int i = 0; i < 2000 && mon_n < 500; i++) tick;
    checks++;
    if (!ok || mon_n != 500) begin errors++; $display("FAIL abort_reach: got %0d writes (start=%b) expected 500", mon_n, ok); end
    enable = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0 || wr_addr !== '0) begin errors++; $display("FAIL abort_idle: got busy=%b addr=%0d expected 0 0", busy, wr_addr); end
    repeat (3) tick;
    checks++;
    if (mon_n != 500 || mon_rdy != 0 || wr_buf !== exp_buf) begin
      errors++;
      $display("FAIL abort_quiet: got writes=%0d pulses=%0d wr_buf=%b expected 500 0 %b", mon_n, mon_rdy, wr_buf, exp_buf);
    end
    enable = 1'b1;
    tick;
    run_frame(2, 16'd2, 16'd2);
    exp_buf = ~exp_buf;
    checks++;
    if (mon_n != 1024 || addr_err != 0 || mon_rdy != 1) begin
      errors++;
      $display("FAIL abort_restart: got writes=%0d addr_err=%0d pulses=%0d expected 1024 0 1", mon_n, addr_err, mon_rdy);
    end
  endtask

  task automatic test_auto_gain;
    int eg[9] = '{1, 2, 3, 3, 3, 2, 1, 0, 0};
    bit es[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    gain_auto_en = 1'b1;
    const_val = 12'd2000;
    tick;
    for (int f = 0; f < 9; f++) begin
      ramp = f >= 5;
      run_frame(2, 16'd2, 16'd2);
      exp_buf = ~exp_buf;
      checks++;
      if (gain_ctrl !== 2'(eg[f])) begin errors++; $display("FAIL auto_gain_f%0d: got %0d expected %0d", f, gain_ctrl, eg[f]); end
      checks++;
      if (gain_stable !== es[f]) begin errors++; $display("FAIL auto_stable_f%0d: got %b expected %b", f, gain_stable, es[f]); end
    end
    checks++;
    if (wr_buf !== exp_buf) begin errors++; $display("FAIL auto_wr_buf: got %b expected %b", wr_buf, exp_buf); end
  endtask

  task automatic test_reset_mid;
    bit ok, seen;
    ramp = 1'b0;
    gain_auto_en = 1'b0;
    gain_manual = 2'd3;
    tick;
    tick;
    clr_mon(2);
    div_cfg = 16'd2;
    start_cap(ok);
    repeat (100) tick;
    checks++;
    if (!ok || busy !== 1'b1 || wr_addr === '0 || gain_ctrl !== 2'd3) begin
      errors++;
      $display("FAIL rst_mid_pre: got busy=%b addr=%0d gain=%0d expected 1 nonzero 3", busy, wr_addr, gain_ctrl);
    end
    signal_in = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, adc_clk, wr_en, buf_ready, overrun} !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid_flags: got %b expected 00000", {busy, adc_clk, wr_en, buf_ready, overrun});
    end
    checks++;
    if (wr_addr !== '0 || wr_data !== '0) begin errors++; $display("FAIL rst_mid_addr: got addr=%0d data=%0h expected 0 0", wr_addr, wr_data); end
    checks++;
    if ({gain_ctrl, gain_stable, wr_buf} !== 4'b0) begin
      errors++;
      $display("FAIL rst_mid_gain: got gain=%0d stable=%b wr_buf=%b expected 0 0 0", gain_ctrl, gain_stable, wr_buf);
    end
    #3;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick;
      if (busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rst_held_trigger: got capture=1 expected 0"); end
    signal_in = 1'b0;
    repeat (4) tick;
    clr_mon(2);
    start_cap(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_new_edge: got capture=0 expected 1"); end
    enable = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_final_abort: got busy=%b expected 0", busy); end
  endtask

  initial begin
    test_reset;
    test_gain_manual;
    test_frame_div4;
    test_div_small;
    test_overrun;
    test_abort;
    test_auto_gain;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
